fft_frame_ctrl: RTL and testbench

Frame sequencer for the 8-point FFT datapath: deserializer -> FFT core -> serializer. Accepts upstream samples with a valid/ready handshake and gates them into the deserializer. Latches complex/real mode once per frame, then starts the core and hands its result to the serializer. Watchdog timers abort stalled frames, and per-frame status is reported.

---
 rtl/fft_frame_ctrl.sv | 92 +++++++++
 tb/tb_fft_frame_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame sequencer gating samples into the deserializer, then
// starting the FFT core and loading the serializer, with a per-wait watchdog.
module fft_frame_ctrl #(
    parameter int N_POINTS = 8,
    parameter int TIMEOUT  = 64,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_real_mode,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             des_input_valid,
    output logic             des_real_mode,
    input  logic             des_output_valid,
    output logic             fft_start,
    input  logic             fft_done,
    input  logic             ser_busy,
    output logic             ser_load,
    output logic             frame_done,
    output logic             busy,
    input  logic             err_clr,
    output logic             err_timeout,
    output logic [CNT_W-1:0] frame_count
);
    localparam int BW = $clog2(N_POINTS + 1);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, COLLECT, WAIT_DES, START, COMPUTE, WAIT_SER, LOAD, DONE
    } state_t;

    state_t          state, state_nx;
    logic   [BW-1:0] beat_cnt, need;
    logic   [TW-1:0] tmr;
    logic            mode_r, accept, expire, set_err;

    assign need    = mode_r ? BW'(N_POINTS / 2) : BW'(N_POINTS);
    assign accept  = s_valid && s_ready;
    assign expire  = tmr == TW'(TIMEOUT - 1);
    // the awaited event wins over the watchdog on the same cycle
    assign set_err = expire && ((state == WAIT_DES && !des_output_valid) ||
                                (state == COMPUTE && !fft_done));

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     state_nx = accept ? COLLECT : IDLE;
            COLLECT:  state_nx = (accept && beat_cnt + 1'b1 == need) ? WAIT_DES : COLLECT;
            WAIT_DES: state_nx = des_output_valid ? START : expire ? IDLE : WAIT_DES;
            START:    state_nx = COMPUTE;
            COMPUTE:  state_nx = fft_done ? WAIT_SER : expire ? IDLE : COMPUTE;
            WAIT_SER: state_nx = ser_busy ? WAIT_SER : LOAD;
            LOAD:     state_nx = DONE;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        s_ready         = state == IDLE || state == COLLECT;
        des_input_valid = s_valid && s_ready;
        des_real_mode   = state == IDLE ? cfg_real_mode : mode_r;
        fft_start       = state == START;
        ser_load        = state == LOAD;
        frame_done      = state == DONE;
        busy            = state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            beat_cnt    <= '0;
            tmr         <= '0;
            mode_r      <= 1'b0;
            err_timeout <= 1'b0;
            frame_count <= '0;
        end else begin
            if (accept) beat_cnt <= state == IDLE ? BW'(1) : beat_cnt + 1'b1;
            if (accept && state == IDLE) mode_r <= cfg_real_mode;
            // zero on entry, so the first cycle of a wait sees tmr == 0
            tmr         <= (state_nx == state && (state == WAIT_DES || state == COMPUTE)) ?
                           tmr + 1'b1 : '0;
            err_timeout <= set_err | (err_timeout & ~err_clr);
            if (state == DONE) frame_count <= frame_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed frames plus randomized peers against a
// cycle-level frame model, compared every cycle.
module tb_fft_frame_ctrl;
    logic        clk = 0, reset_n = 0, cfg_real_mode = 0, s_valid = 0;
    logic        des_output_valid = 0, fft_done = 0, ser_busy = 0, err_clr = 0;
    logic        s_ready, des_input_valid, des_real_mode, fft_start, ser_load;
    logic        frame_done, busy, err_timeout;
    logic [15:0] frame_count;

    fft_frame_ctrl #(.N_POINTS(8), .TIMEOUT(64), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_real_mode(cfg_real_mode),
        .s_valid(s_valid), .s_ready(s_ready), .des_input_valid(des_input_valid),
        .des_real_mode(des_real_mode), .des_output_valid(des_output_valid),
        .fft_start(fft_start), .fft_done(fft_done), .ser_busy(ser_busy),
        .ser_load(ser_load), .frame_done(frame_done), .busy(busy),
        .err_clr(err_clr), .err_timeout(err_timeout), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int n_div = 0, n_start = 0, n_load = 0, n_done = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: phase 0 idle, 1 gathering beats, 2 awaiting deserializer,
    // 3 start pulse, 4 awaiting core, 5 awaiting serializer, 6 load, 7 done.
    int          ph = 0, got = 0, age = 0, nph;
    bit          m_mode = 0, m_err = 0, expired;
    logic [15:0] m_cnt = 0;

    always @(posedge clk) begin
        if (!reset_n) begin
            ph = 0; got = 0; age = 0; m_mode = 0; m_err = 0; m_cnt = 0;
        end else begin
            expired = 0;
            nph = ph;
            if (ph == 0 && s_valid) begin
                m_mode = cfg_real_mode; got = 1; nph = 1;
            end else if (ph == 1 && s_valid) begin
                got++;
                if (got == (m_mode ? 4 : 8)) nph = 2;
            end else if (ph == 2 || ph == 4) begin
                if (ph == 2 ? des_output_valid : fft_done) nph = ph + 1;
                else if (age == 63) begin expired = 1; nph = 0; end
            end else if (ph == 3 || ph == 6) nph = ph + 1;
            else if (ph == 5 && !ser_busy) nph = 6;
            else if (ph == 7) begin m_cnt++; nph = 0; end
            age = (nph == ph) ? age + 1 : 0;
            m_err = expired | (m_err & !err_clr);
            ph = nph;
        end
    end

    always @(negedge clk) if (chk_en) begin
        chk("s_ready", s_ready, ph <= 1);
        chk("des_input_valid", des_input_valid, s_valid && ph <= 1);
        chk("des_real_mode", des_real_mode, ph == 0 ? cfg_real_mode : m_mode);
        chk("fft_start", fft_start, ph == 3);
        chk("ser_load", ser_load, ph == 6);
        chk("frame_done", frame_done, ph == 7);
        chk("busy", busy, ph != 0);
        chk("err_timeout", err_timeout, m_err);
        chk("frame_count", frame_count, m_cnt);
        n_div   += int'(des_input_valid);
        n_start += int'(fft_start);
        n_load  += int'(ser_load);
        n_done  += int'(frame_done);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beats(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            s_valid = gap ? (i % 2 == 0) : 1'b1;
            tick;
        end
        s_valid = 0;
    endtask

    task automatic finish_frame;
        des_output_valid = 1; tick; des_output_valid = 0;
        tick;
        fft_done = 1; tick; fft_done = 0;
        repeat (4) tick;
    endtask

    task automatic clr_counts;
        n_div = 0; n_start = 0; n_load = 0; n_done = 0;
    endtask

    int k;

    initial begin
        tick;
        chk_en = 1;
        tick;
        reset_n = 1;
        chk("rst s_ready", s_ready, 1);
        chk("rst busy", busy, 0);
        chk("rst frame_count", frame_count, 0);
        chk("rst err", err_timeout, 0);

        // complex frame, zero-wait peers
        clr_counts;
        beats(8, 0);
        chk("cplx s_ready low", s_ready, 0);
        des_output_valid = 1; tick; des_output_valid = 0;
        tick; tick; tick;
        fft_done = 1; tick; fft_done = 0;
        repeat (4) tick;
        chk("cplx beats", n_div, 8);
        chk("cplx starts", n_start, 1);
        chk("cplx loads", n_load, 1);
        chk("cplx dones", n_done, 1);
        chk("cplx count", frame_count, 1);
        chk("cplx busy", busy, 0);

        // real mode with cfg toggled mid-frame
        clr_counts;
        cfg_real_mode = 1; s_valid = 1; tick; tick;
        cfg_real_mode = 0; repeat (4) tick; s_valid = 0;
        chk("real beats", n_div, 4);
        chk("real mode held", des_real_mode, 1);
        finish_frame;
        chk("real count", frame_count, 2);

        // alternate-cycle input
        clr_counts;
        beats(18, 1);
        chk("gap beats", n_div, 8);
        chk("gap s_ready low", s_ready, 0);
        finish_frame;
        chk("gap count", frame_count, 3);

        // serializer backpressure
        clr_counts;
        beats(8, 0);
        ser_busy = 1;
        des_output_valid = 1; tick; des_output_valid = 0;
        tick;
        fft_done = 1; tick; fft_done = 0;
        repeat (5) tick;
        chk("bp no load yet", n_load, 0);
        ser_busy = 0;
        repeat (4) tick;
        chk("bp loads", n_load, 1);
        chk("bp count", frame_count, 4);

        // watchdog in COMPUTE
        beats(8, 0);
        des_output_valid = 1; tick; des_output_valid = 0;
        for (k = 1; k <= 80; k++) begin
            tick;
            if (err_timeout) break;
        end
        chk("wd latency", k, 65);
        chk("wd count", frame_count, 4);
        chk("wd busy", busy, 0);
        err_clr = 1; tick; err_clr = 0;
        chk("wd cleared", err_timeout, 0);

        // reset mid-collect, stray fft_done, then full frame
        beats(5, 0);
        reset_n = 0; tick; reset_n = 1;
        chk("mid rst busy", busy, 0);
        chk("mid rst s_ready", s_ready, 1);
        chk("mid rst count", frame_count, 0);
        fft_done = 1; tick; fft_done = 0;
        chk("stray done busy", busy, 0);
        clr_counts;
        beats(7, 0);
        chk("seven beats open", s_ready, 1);
        beats(1, 0);
        chk("eight beats closed", s_ready, 0);
        finish_frame;
        chk("post rst count", frame_count, 1);

        // randomized peers
        repeat (4000) begin
            s_valid          = $urandom % 3 != 0;
            cfg_real_mode    = $urandom % 2 == 1;
            des_output_valid = $urandom % 20 == 0;
            fft_done         = $urandom % 12 == 0;
            ser_busy         = $urandom % 3 == 0;
            err_clr          = $urandom % 30 == 0;
            reset_n          = $urandom % 400 != 0;
            tick;
        end
        reset_n = 1; s_valid = 0; des_output_valid = 0; fft_done = 0;
        ser_busy = 0; err_clr = 0;
        tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
